// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock controller.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StStopPend
   } clk_div_state_e;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter with active/pending divisor registers and load apply/ack logic.
module half_period_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W        = CNT_W_DEF,
   parameter int unsigned DEFAULT_HALF = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             count_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] half_period_i,
   output logic             tc_o,
   output logic             load_ack_o,
   output logic             err_o
);

   localparam logic [CNT_W-1:0] One = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             load_ok;
   logic             tc;

   always_comb begin
      load_ok    = load_i && (half_period_i != '0);
      err_d      = load_i && (half_period_i == '0);
      tc         = count_i && (cnt_q == (div_q - One));
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ack_d      = 1'b0;

      if (!count_i) begin
         // Idle: no half-period in progress, so a new divisor can go live at once.
         if (load_ok) begin
            div_d      = half_period_i;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
         end else if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
         end
      end else begin
         if (tc && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
         end
         if (load_ok) begin
            pend_d     = half_period_i;
            pend_vld_d = 1'b1;
         end
      end

      if (!count_i || clear_i || tc) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + One;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         div_q      <= CNT_W'(DEFAULT_HALF);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign tc_o       = tc;
   assign load_ack_o = ack_q;
   assign err_o      = err_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop FSM plus registered level and edge pulses.
// Define CLK_DIV_CTRL_EDGE_CNT_EN to add the 32-bit edge counter and edge_cnt_o.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W        = CNT_W_DEF,
   parameter int unsigned DEFAULT_HALF = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] half_period_i,
   output logic             busy_o,
   output logic             div_clk_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             edge_o,
   output logic             load_ack_o,
   output logic             err_o
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
   ,
   output logic [31:0]      edge_cnt_o
`endif
);

   clk_div_state_e state_q, state_d;
   logic           div_clk_q, div_clk_d;
   logic           rise_q, rise_d;
   logic           fall_q, fall_d;
   logic           edge_q, edge_d;
   logic           toggle;
   logic           tc;

   half_period_counter #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) u_counter (
      .clk_i         (clk),
      .rst_i         (rst),
      .count_i       (state_q != StIdle),
      .clear_i       (state_d == StIdle),
      .load_i        (load_i),
      .half_period_i (half_period_i),
      .tc_o          (tc),
      .load_ack_o    (load_ack_o),
      .err_o         (err_o)
   );

   always_comb begin
      state_d = state_q;
      toggle  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !stop_i) state_d = StRun;
         end
         StRun: begin
            if (stop_i) begin
               // Stopping from a low level parks immediately; from high we wait for the fall.
               if (div_clk_q) begin
                  toggle  = tc;
                  state_d = tc ? StIdle : StStopPend;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               toggle = tc;
            end
         end
         StStopPend: begin
            toggle = tc;
            if (start_i) begin
               state_d = StRun;
            end else if (tc) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      div_clk_d = div_clk_q ^ toggle;
      rise_d    = toggle & ~div_clk_q;
      fall_d    = toggle & div_clk_q;
      edge_d    = toggle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         div_clk_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         edge_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_clk_q <= div_clk_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         edge_q    <= edge_d;
      end
   end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
   logic [31:0] edge_cnt_q, edge_cnt_d;

   always_comb begin
      edge_cnt_d = edge_cnt_q + {31'd0, toggle};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

   assign edge_cnt_o = edge_cnt_q;
`endif

   assign busy_o    = (state_q != StIdle);
   assign div_clk_o = div_clk_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign edge_o    = edge_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a cycle model queues expected outputs per driven cycle.
module tb_clk_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        load_i = 1'b0;
   logic [15:0] half_period_i = '0;
   logic        busy_o, div_clk_o, rise_o, fall_o, edge_o, load_ack_o, err_o;
   logic [6:0]  outs;

   int n_checks = 0;
   int n_fail   = 0;
   int step     = 0;
   int s0;
   string phase = "init";

   logic [6:0]  exp_q[$];
   int          rise_steps[$];
   int          fall_steps[$];

   // Reference model state
   int          m_st, m_cnt, m_div, m_pend;
   bit          m_pvld, m_clk;
   logic [31:0] m_ecnt;

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
   logic [31:0] edge_cnt_o;
   logic [31:0] ecnt_q[$];
`endif

   clk_div_ctrl #(
      .CNT_W        (16),
      .DEFAULT_HALF (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .load_i        (load_i),
      .half_period_i (half_period_i),
      .busy_o        (busy_o),
      .div_clk_o     (div_clk_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .edge_o        (edge_o),
      .load_ack_o    (load_ack_o),
      .err_o         (err_o)
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
      ,
      .edge_cnt_o    (edge_cnt_o)
`endif
   );

   assign outs = {busy_o, div_clk_o, rise_o, fall_o, edge_o, load_ack_o, err_o};

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h expected %0h", tag, step, act, exp);
      end
   endtask

   function automatic int rise_at(input int i);
      return (rise_steps.size() > i) ? rise_steps[i] : -1000;
   endfunction

   function automatic int fall_at(input int i);
      return (fall_steps.size() > i) ? fall_steps[i] : -1000;
   endfunction

   // Predicts the registered outputs after the coming edge from the driven inputs.
   task automatic model_step();
      bit tc, tog, ld_ok, err, ack, r_p, f_p;
      int nst;
      if (rst) begin
         m_st = 0; m_cnt = 0; m_div = 4; m_pend = 0; m_pvld = 0; m_clk = 0; m_ecnt = '0;
         exp_q.push_back('0);
      end else begin
         ld_ok = load_i && (half_period_i != 16'd0);
         err   = load_i && (half_period_i == 16'd0);
         tc    = (m_st != 0) && (m_cnt + 1 == m_div);
         tog   = 0;
         nst   = m_st;
         case (m_st)
            0: if (start_i && !stop_i) nst = 1;
            1: begin
               if (stop_i) begin
                  if (!m_clk) nst = 0;
                  else begin tog = tc; nst = tc ? 0 : 2; end
               end else tog = tc;
            end
            default: begin
               tog = tc;
               if (start_i) nst = 1;
               else if (tc) nst = 0;
            end
         endcase
         r_p = tog && !m_clk;
         f_p = tog && m_clk;
         ack = 0;
         if (m_st == 0) begin
            if (ld_ok) begin m_div = int'(half_period_i); m_pvld = 0; ack = 1; end
            else if (m_pvld) begin m_div = m_pend; m_pvld = 0; ack = 1; end
         end else begin
            if (tc && m_pvld) begin m_div = m_pend; m_pvld = 0; ack = 1; end
            if (ld_ok) begin m_pend = int'(half_period_i); m_pvld = 1; end
         end
         m_cnt = (m_st == 0 || nst == 0 || tc) ? 0 : m_cnt + 1;
         if (tog) begin
            m_clk  = !m_clk;
            m_ecnt = m_ecnt + 32'd1;
         end
         m_st = nst;
         exp_q.push_back({nst != 0, m_clk, r_p, f_p, tog, ack, err});
      end
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
      ecnt_q.push_back(m_ecnt);
`endif
   endtask

   task automatic drive(input logic r, input logic st, input logic sp, input logic ld,
                        input logic [15:0] hp);
      logic [6:0] e;
      @(negedge clk);
      rst = r; start_i = st; stop_i = sp; load_i = ld; half_period_i = hp;
      model_step();
      @(posedge clk);
      #1;
      step++;
      e = exp_q.pop_front();
      check_eq({phase, "_outs"}, 32'(outs), 32'(e));
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
      check_eq({phase, "_ecnt"}, edge_cnt_o, ecnt_q.pop_front());
`endif
      if (rise_o) rise_steps.push_back(step);
      if (fall_o) fall_steps.push_back(step);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
   endtask

   task automatic clear_edges();
      rise_steps.delete();
      fall_steps.delete();
   endtask

   // Advances until the model's level matches lvl (and, if want_cnt0, a half-period just began).
   task automatic wait_level(input bit lvl, input bit want_cnt0);
      bit found = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_clk == lvl && (!want_cnt0 || m_cnt == 0) && m_st != 0) begin
            found = 1;
            break;
         end
         idle(1);
      end
      if (!found) check_eq({phase, "_wait_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      phase = "reset";
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      check_eq("reset_all_zero", 32'(outs), 32'd0);

      // Default divisor 4
      phase = "div4";
      clear_edges();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      s0 = step;
      check_eq("run_entry_busy", 32'(busy_o), 32'd1);
      idle(24);
      check_eq("first_rise_latency", 32'(rise_at(0) - s0), 32'd4);
      check_eq("fall_after_rise", 32'(fall_at(0) - rise_at(0)), 32'd4);
      check_eq("rise_period", 32'(rise_at(1) - rise_at(0)), 32'd8);

      // Zero load errors, divisor 1 load applies on next toggle
      phase = "load";
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      check_eq("zero_load_err", 32'(err_o), 32'd1);
      idle(3);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
      idle(8);
      clear_edges();
      idle(6);
      check_eq("div1_rises_in_6", 32'(rise_steps.size()), 32'd3);
      check_eq("div1_falls_in_6", 32'(fall_steps.size()), 32'd3);

      // Divisor 3, stop while high goes through STOP_PEND
      phase = "stop_high";
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd3);
      idle(8);
      wait_level(1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      check_eq("stop_pend_busy", 32'(busy_o), 32'd1);
      idle(2);
      check_eq("stop_pend_fall", 32'(fall_o), 32'd1);
      check_eq("stop_pend_idle", 32'(busy_o), 32'd0);
      idle(5);
      check_eq("parked_low", 32'(div_clk_o), 32'd0);

      // Start cancels a pending stop with no missing edge
      phase = "cancel";
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      clear_edges();
      wait_level(1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      check_eq("cancel_busy", 32'(busy_o), 32'd1);
      idle(8);
      check_eq("cancel_fall_spacing", 32'(fall_at(0) - rise_at(0)), 32'd3);
      check_eq("cancel_rise_spacing", 32'(rise_at(1) - rise_at(0)), 32'd6);

      // Stop while low, then start & stop together in IDLE
      phase = "start_stop";
      wait_level(1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
      clear_edges();
      idle(6);
      check_eq("start_stop_idle", 32'(busy_o), 32'd0);
      check_eq("start_stop_no_edges", 32'(rise_steps.size() + fall_steps.size()), 32'd0);

      // Reset mid-run drops pending load and restores divisor 4
      phase = "mid_reset";
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      idle(6);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'd7);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      check_eq("mid_reset_zero", 32'(outs), 32'd0);
      clear_edges();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      s0 = step;
      idle(10);
      check_eq("post_reset_latency", 32'(rise_at(0) - s0), 32'd4);
      check_eq("post_reset_period", 32'(fall_at(0) - rise_at(0)), 32'd4);

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
      phase = "edge_cnt";
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      check_eq("edge_cnt_reset", edge_cnt_o, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      idle(82);
      check_eq("edge_cnt_10_periods", edge_cnt_o, 32'd20);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      idle(3);
      check_eq("edge_cnt_kept_over_stop", edge_cnt_o, 32'd20);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable divided-clock controller that sequences a single-clock-domain tick source for downstream logic. Generates a divided clock level plus one-cycle rising-, falling- and any-edge event pulses, all synchronous to `clk`. Supports start/stop handshakes and glitch-free divisor reprogramming. Sits between the testbench/register front-end and any block that needs periodic edge events without a second clock domain.

## Interface
- `CNT_W`, 16: width of half-period counter and divisor.
- `DEFAULT_HALF`, 4: half-period (in `clk` cycles) loaded at reset; must be ≥1.

- `clk`  in  1  system clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request to begin toggling.
- `stop_i`  in  1  request to stop, div clock parked low.
- `load_i`  in  1  load `half_period_i` as new divisor.
- `half_period_i`  in  CNT_W  requested half-period in `clk` cycles.
- `busy_o`  out  1  high in RUN or STOP_PEND.
- `div_clk_o`  out  1  divided clock level.
- `rise_o`  out  1  one-cycle pulse, same cycle `div_clk_o` goes 0→1.
- `fall_o`  out  1  one-cycle pulse, same cycle `div_clk_o` goes 1→0.
- `edge_o`  out  1  `rise_o | fall_o`.
- `load_ack_o`  out  1  one-cycle pulse when new divisor takes effect.
- `err_o`  out  1  one-cycle pulse when `load_i` carries zero.
- `edge_cnt_o`  out  32  edge count (only with `CLK_DIV_CTRL_EDGE_CNT_EN`).

## Operation
- States: IDLE, RUN, STOP_PEND. Reset → IDLE, divisor = `DEFAULT_HALF`, counter = 0, all outputs 0.
- IDLE: `div_clk_o` low, counter held 0. `start_i` → RUN. `start_i & stop_i` together → stay IDLE (stop wins).
- RUN: counter increments each cycle; when counter == divisor−1, counter → 0 and `div_clk_o` toggles with matching `rise_o`/`fall_o`. `start_i` ignored. `stop_i` → STOP_PEND if `div_clk_o` high, else directly IDLE (no edge generated).
- STOP_PEND: keeps counting; at next fall → IDLE. `start_i` cancels stop → RUN, counter undisturbed. `stop_i` ignored.
- Load: `load_i` with `half_period_i` = 0 → `err_o` pulse, request discarded. Nonzero value captured into a pending register (later load overwrites earlier unapplied one). In IDLE applied next cycle; in RUN/STOP_PEND applied on the next toggle cycle. `load_ack_o` pulses in the cycle the value becomes active.
- Divisor arithmetic unsigned CNT_W; counter compare uses active divisor only, pending value never affects an in-progress half-period.

## Timing
- `start_i` sampled at edge N → RUN at N+1, counter 0; first `rise_o` and `div_clk_o`=1 registered at edge N+divisor+1... i.e. visible divisor cycles after RUN entry.
- Period = 2×divisor cycles; divisor 1 → `div_clk_o` toggles every cycle, `rise_o`/`fall_o` alternate every cycle.
- All outputs registered; no combinational path from inputs to outputs.
- `rst` mid-operation: next cycle IDLE, outputs 0, pending load dropped, divisor back to `DEFAULT_HALF`.

## Configuration
- `CLK_DIV_CTRL_EDGE_CNT_EN` defined: `edge_cnt_o` port present; 32-bit counter increments on every `edge_o`, wraps 0xFFFF_FFFF→0, cleared by `rst` only (not by stop).
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package `clk_div_pkg`: state enum `clk_div_state_e` (IDLE, RUN, STOP_PEND), default `CNT_W` constant.
- One sub-module `half_period_counter`: counter, active/pending divisor registers, terminal-count output, load apply/ack logic. Top holds FSM and edge outputs.

## Test plan
- Reset then `start_i` with default divisor 4 → `rise_o` 4 cycles after RUN entry, then `fall_o` every 8 cycles offset by 4; `edge_o` every 4 cycles.
- `load_i` 0 → `err_o` one cycle, period unchanged; `load_i` 1 in RUN → `load_ack_o` on next toggle, thereafter toggle every cycle.
- `stop_i` while `div_clk_o` high with divisor 3 → STOP_PEND, `fall_o` at next terminal count, `busy_o` low next cycle, `div_clk_o` stays 0.
- `stop_i` then `start_i` during STOP_PEND → no stop, period continuous, no missing edge.
- `start_i & stop_i` same cycle in IDLE → remains IDLE, no edges; `rst` asserted mid-RUN → all outputs 0 next cycle, divisor 4.
- With `CLK_DIV_CTRL_EDGE_CNT_EN`, 10 full periods → `edge_cnt_o` = 20; stop/start does not clear it.
